// File: rtl/doodle_engine.sv
// Doodle game engine: jump/fall FSM, platform collision,
// endless vertical scroll, score and registered pixel colour.
module doodle_engine #(
   parameter int N_PLAT      = 12,
   parameter int PLAT_W      = 64,
   parameter int PLAT_H      = 16,
   parameter int DOODLE_R    = 10,
   parameter int H_MIN       = 144,
   parameter int H_MAX       = 783,
   parameter int V_MIN       = 35,
   parameter int V_MAX       = 515,
   parameter int X_INIT      = 406,
   parameter int Y_INIT      = 477,
   parameter int STEP        = 2,
   parameter int JUMP_H      = 96,
   parameter int SCROLL_LINE = 200,
   parameter int TILT_W      = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 start,
   input  logic                 left,
   input  logic                 right,
   input  logic [TILT_W-1:0]    tilt,
   input  logic [9:0]           hCount,
   input  logic [9:0]           vCount,
   input  logic                 bright,
   input  logic [N_PLAT*10-1:0] plat_x,
   input  logic [N_PLAT*10-1:0] plat_y,
   output logic [9:0]           xpos,
   output logic [9:0]           ypos,
   output logic [9:0]           scroll,
   output logic [15:0]          score,
   output logic [1:0]           state,
   output logic                 game_over,
   output logic [11:0]          rgb
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RISE = 2'd1;
   localparam logic [1:0] FALL = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [10:0] SPAN = 11'(H_MAX - H_MIN + 1);
   localparam logic [10:0] R    = 11'(DOODLE_R);
   localparam logic [10:0] STP  = 11'(STEP);

   logic [1:0]        nstate;
   logic [9:0]        rise_cnt;
   logic [10:0]       x11, y11, h11, v11;
   logic [10:0]       xr, xl, bot, scr_s;
   logic [9:0]        nx, land_y, scr_n;
   logic              land, dead, jump_end, in_box;
   logic [15:0]       score_n;
   logic [10:0]       pt [N_PLAT];
   logic [10:0]       px [N_PLAT];
   logic [N_PLAT-1:0] hit, on_plat;

   assign x11 = {1'b0, xpos};
   assign y11 = {1'b0, ypos};
   assign h11 = {1'b0, hCount};
   assign v11 = {1'b0, vCount};
   assign bot = y11 + R;

   // Screen top of each platform after applying the wrapping scroll
   for (genvar i = 0; i < N_PLAT; i++) begin : g_plat
      logic [10:0] sum;
      assign sum = {1'b0, plat_y[10*i +: 10]} + {1'b0, scroll};
      assign pt[i] = (sum >= 11'd480 ? sum - 11'd480 : sum)
                   + 11'(V_MIN);
      assign px[i] = {1'b0, plat_x[10*i +: 10]};
      assign hit[i] = (pt[i] > bot) && (pt[i] <= bot + STP)
                   && (x11 + R >= px[i])
                   && (x11 <= px[i] + 11'(PLAT_W - 1) + R);
      assign on_plat[i] = (h11 >= px[i])
                       && (h11 <= px[i] + 11'(PLAT_W - 1))
                       && (v11 >= pt[i])
                       && (v11 <= pt[i] + 11'(PLAT_H - 1));
   end

   assign xr = x11 + 11'(tilt);
   assign xl = x11 - 11'(tilt);
   assign scr_s = {1'b0, scroll} + STP;
   assign scr_n = 10'(scr_s >= 11'd480 ? scr_s - 11'd480 : scr_s);
   assign dead = (y11 + STP + R) > 11'(V_MAX);
   assign jump_end = ({1'b0, rise_cnt} + STP) >= 11'(JUMP_H);
   assign score_n = (score > 16'hFFFF - 16'(STEP)) ? 16'hFFFF
                  : score + 16'(STEP);
   assign in_box = (h11 + R >= x11) && (h11 <= x11 + R)
                && (v11 + R >= y11) && (v11 <= y11 + R);

   always_comb begin
      nx = xpos;
      if (right)
         nx = 10'(xr > 11'(H_MAX) ? xr - SPAN : xr);
      else if (left)
         nx = 10'(xl < 11'(H_MIN) ? xl + SPAN : xl);
   end

   // Scan downward so the lowest index wins
   always_comb begin
      land   = 1'b0;
      land_y = '0;
      for (int i = N_PLAT - 1; i >= 0; i--) begin
         if (hit[i]) begin
            land   = 1'b1;
            land_y = 10'(pt[i] - R - 11'd1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: if (start) nstate = RISE;
         RISE: if (tick && jump_end) nstate = FALL;
         FALL: begin
            if (tick) begin
               if (land)      nstate = RISE;
               else if (dead) nstate = DONE;
            end
         end
         DONE: if (start) nstate = IDLE;
      endcase
   end

   always_comb begin
      game_over = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xpos     <= 10'(X_INIT);
         ypos     <= 10'(Y_INIT);
         scroll   <= '0;
         score    <= '0;
         rise_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) rise_cnt <= '0;
            RISE: begin
               if (tick) begin
                  xpos <= nx;
                  if (y11 < 11'(SCROLL_LINE) + STP)
                     scroll <= scr_n;
                  else
                     ypos <= ypos - 10'(STEP);
                  score    <= score_n;
                  rise_cnt <= rise_cnt + 10'(STEP);
               end
            end
            FALL: begin
               if (tick) begin
                  xpos <= nx;
                  if (land) begin
                     ypos     <= land_y;
                     rise_cnt <= '0;
                  end else begin
                     ypos <= ypos + 10'(STEP);
                  end
               end
            end
            DONE: begin
               if (start) begin
                  xpos     <= 10'(X_INIT);
                  ypos     <= 10'(Y_INIT);
                  scroll   <= '0;
                  score    <= '0;
                  rise_cnt <= '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          rgb <= '0;
      else if (!bright)                  rgb <= '0;
      else if (state == DONE || in_box)  rgb <= 12'hF00;
      else if (|on_plat)                 rgb <= 12'h0F0;
      else                               rgb <= '0;
   end

endmodule
